// File: rtl/line_buffer_col_reader.sv
// 4-tap vertical column reader over a 3-line buffer for the bicubic window stage.
// Optional top-edge replication of row 0 is enabled by defining LB_REPLICATE_TOP_EN.
module line_buffer_col_reader #(
  parameter int unsigned IMG_W = 960,
  parameter int unsigned DW    = 24,
  parameter int unsigned AW    = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  input  logic            s_sof,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [4*DW-1:0] m_col,
  output logic [AW-1:0]   m_x,
  output logic            m_eol
);

  localparam int unsigned CW = 4 * DW;

  typedef enum logic {FILL, STREAM} state_e;

  logic [DW-1:0] lm0_q [IMG_W];
  logic [DW-1:0] lm1_q [IMG_W];
  logic [DW-1:0] lm2_q [IMG_W];

  state_e        state_q, state_d;
  logic [AW-1:0] x_q, x_d;
  logic [1:0]    row_q, row_d;
  logic          m_valid_q, m_valid_d;
  logic [CW-1:0] m_col_q, m_col_d;
  logic [AW-1:0] m_x_q, m_x_d;
  logic          m_eol_q, m_eol_d;

  logic          accept_c, wrap_c, emit_c;
  logic [AW-1:0] x_eff_c;
  logic [1:0]    row_eff_c;
  state_e        state_eff_c;
  logic [DW-1:0] t0_c, t1_c, t2_c;
  logic [CW-1:0] col_c;

  // Single output register: a new pixel is taken whenever the slot is free or draining.
  assign s_ready = !m_valid_q | m_ready;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    row_d     = row_q;
    m_valid_d = m_valid_q;
    m_col_d   = m_col_q;
    m_x_d     = m_x_q;
    m_eol_d   = m_eol_q;

    accept_c    = s_valid & s_ready;
    // An accepted start-of-frame pixel is column 0 of row 0 regardless of counters.
    x_eff_c     = s_sof ? '0 : x_q;
    row_eff_c   = s_sof ? 2'd0 : row_q;
    state_eff_c = s_sof ? FILL : state_q;
    t0_c        = lm0_q[x_eff_c];
    t1_c        = lm1_q[x_eff_c];
    t2_c        = lm2_q[x_eff_c];
    wrap_c      = (x_eff_c == AW'(IMG_W - 1));
    col_c       = {t2_c, t1_c, t0_c, s_data};

`ifdef LB_REPLICATE_TOP_EN
    emit_c = accept_c;
    // Missing older rows are replaced by the oldest row of the frame.
    case (row_eff_c)
      2'd0:    col_c = {s_data, s_data, s_data, s_data};
      2'd1:    col_c = {t0_c, t0_c, t0_c, s_data};
      2'd2:    col_c = {t1_c, t1_c, t0_c, s_data};
      default: col_c = {t2_c, t1_c, t0_c, s_data};
    endcase
`else
    emit_c = accept_c && (state_eff_c == STREAM);
`endif

    if (accept_c) begin
      x_d   = wrap_c ? '0 : x_eff_c + AW'(1);
      row_d = (wrap_c && row_eff_c != 2'd3) ? row_eff_c + 2'd1 : row_eff_c;
      case (state_eff_c)
        FILL:    state_d = (wrap_c && row_eff_c == 2'd2) ? STREAM : FILL;
        STREAM:  state_d = STREAM;
        default: state_d = FILL;
      endcase
      m_valid_d = emit_c;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    if (emit_c) begin
      m_col_d = col_c;
      m_x_d   = x_eff_c;
      m_eol_d = wrap_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      x_q       <= '0;
      row_q     <= 2'd0;
      m_valid_q <= 1'b0;
      m_col_q   <= '0;
      m_x_q     <= '0;
      m_eol_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      row_q     <= row_d;
      m_valid_q <= m_valid_d;
      m_col_q   <= m_col_d;
      m_x_q     <= m_x_d;
      m_eol_q   <= m_eol_d;
    end
  end

  // Line memories shift one line older per accept; contents are not reset.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      lm0_q[x_eff_c] <= s_data;
      lm1_q[x_eff_c] <= t0_c;
      lm2_q[x_eff_c] <= t1_c;
    end
  end

  assign m_valid = m_valid_q;
  assign m_col   = m_col_q;
  assign m_x     = m_x_q;
  assign m_eol   = m_eol_q;

endmodule
